// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the SRAM arbiter.
package sram_arb_pkg;

   localparam int SRAM_AW = 21;
   localparam int WORD_AW = 16;
   localparam int BANK_W  = 4;
   localparam int DATA_W  = 16;
   localparam int BYTE_W  = 8;
   localparam int CNT_W   = 4;

   // SRAM strobes are active-low
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_STROBE  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_ACK     = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: grant selection between the two requesters.
// When both ask, ptr names the winner; a constant 0 gives fixed port-0 priority.
module sram_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic grant,
   output logic valid
);

   // A lone requester always wins; a tie goes to the port named by ptr
   always_comb begin
      valid = req0 | req1;
      grant = (req0 & req1) ? ptr : req1;
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 8-bit SRAM between two 16-bit word requesters,
// splitting each word into a low-byte then a high-byte access.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; without it
// port 0 has fixed priority and no pointer register exists.
//
// state   | meaning
// IDLE    | waiting for a request; byte_sel cleared
// ADDR    | ce low, address (and write data) set up for one byte
// STROBE  | oe (read) or we (write) low for WAIT_CYCLES cycles
// RELEASE | strobes high, ce/address/write data held
// ACK     | one-cycle completion pulse to the granted port
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int                WAIT_CYCLES = 2,
   parameter logic [BANK_W-1:0] PORT0_BANK  = 4'h0,
   parameter logic [BANK_W-1:0] PORT1_BANK  = 4'h1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               p0_req,
   input  logic               p1_req,
   input  logic               p0_we,
   input  logic               p1_we,
   input  logic [WORD_AW-1:0] p0_addr,
   input  logic [WORD_AW-1:0] p1_addr,
   input  logic [DATA_W-1:0]  p0_wdata,
   input  logic [DATA_W-1:0]  p1_wdata,
   output logic [DATA_W-1:0]  p0_rdata,
   output logic [DATA_W-1:0]  p1_rdata,
   output logic               p0_ack,
   output logic               p1_ack,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [BYTE_W-1:0]  sram_dout,
   output logic               sram_drive,
   input  logic [BYTE_W-1:0]  sram_din,
   output logic               sram_ce,
   output logic               sram_oe,
   output logic               sram_we
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   arb_state_t         state_q, state_d;
   logic               bsel_q;
   logic               gnt_q;
   logic               we_q;
   logic [WORD_AW-1:0] addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata0_q, rdata1_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               rr_ptr;
   logic               pick_grant, pick_valid;
   logic               active;
   logic [BANK_W-1:0]  bank;

   sram_arb_pick u_pick (
      .req0  (p0_req),
      .req1  (p1_req),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .valid (pick_valid)
   );

`ifdef SRAM_ARB_RR_EN
   // After each completion the port that was not just served gets the next tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  rr_ptr <= 1'b0;
      else if (state_q == ST_ACK) rr_ptr <= ~gnt_q;
   end
`else
   assign rr_ptr = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next state and SRAM strobes / acks, decoded from the current state
   always_comb begin
      state_d    = state_q;
      sram_ce    = STROBE_OFF;
      sram_oe    = STROBE_OFF;
      sram_we    = STROBE_OFF;
      sram_drive = 1'b0;
      p0_ack     = 1'b0;
      p1_ack     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            sram_ce    = STROBE_ON;
            sram_drive = we_q;
            state_d    = ST_STROBE;
         end
         ST_STROBE: begin
            sram_ce    = STROBE_ON;
            sram_drive = we_q;
            if (we_q) sram_we = STROBE_ON;
            else      sram_oe = STROBE_ON;
            if (cnt_q == '0) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            sram_ce    = STROBE_ON;
            sram_drive = we_q;
            state_d    = bsel_q ? ST_ACK : ST_ADDR;
         end
         ST_ACK: begin
            p0_ack  = ~gnt_q;
            p1_ack  = gnt_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latch, byte select, strobe down-counter and read-data capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bsel_q   <= 1'b0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bsel_q <= 1'b0;
               if (pick_valid) begin
                  gnt_q   <= pick_grant;
                  we_q    <= pick_grant ? p1_we    : p0_we;
                  addr_q  <= pick_grant ? p1_addr  : p0_addr;
                  wdata_q <= pick_grant ? p1_wdata : p0_wdata;
               end
            end
            ST_ADDR: cnt_q <= CNT_LOAD;
            ST_STROBE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (!we_q) begin
                  // Last strobe edge: the SRAM output has settled for the full strobe
                  if (!gnt_q) begin
                     if (bsel_q) rdata0_q[15:8] <= sram_din;
                     else        rdata0_q[7:0]  <= sram_din;
                  end else begin
                     if (bsel_q) rdata1_q[15:8] <= sram_din;
                     else        rdata1_q[7:0]  <= sram_din;
                  end
               end
            end
            ST_RELEASE: bsel_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign active    = (state_q == ST_ADDR) || (state_q == ST_STROBE) || (state_q == ST_RELEASE);
   assign bank      = gnt_q ? PORT1_BANK : PORT0_BANK;
   assign sram_addr = active ? {bank, addr_q, bsel_q} : '0;
   assign sram_dout = sram_drive ? (bsel_q ? wdata_q[15:8] : wdata_q[7:0]) : '0;
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: three arbiters (WAIT_CYCLES 2, 1, 15) against a byte-wide
// SRAM model; expectations come from a word-level memory model per port.
module tb_sram_arbiter;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst;

   logic        p0_req [NDUT], p1_req [NDUT], p0_we [NDUT], p1_we [NDUT];
   logic [15:0] p0_addr [NDUT], p1_addr [NDUT], p0_wdata [NDUT], p1_wdata [NDUT];
   logic [15:0] p0_rdata [NDUT], p1_rdata [NDUT];
   logic        p0_ack [NDUT], p1_ack [NDUT];
   logic [20:0] sram_addr [NDUT];
   logic [7:0]  sram_dout [NDUT], sram_din [NDUT];
   logic        sram_drive [NDUT], sram_ce [NDUT], sram_oe [NDUT], sram_we [NDUT];

   logic [7:0]  sram_mem [NDUT][128];
   logic        mem_init;

   logic [15:0] ref_mem [NDUT][2][32];
   logic [15:0] last_rd [NDUT][2];
   int          last_served [NDUT];

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          d;
      logic [20:0] addr;
      logic [7:0]  dout;
      logic        wr;
      int          width;
   } bcyc_t;
   bcyc_t blog[$];
   bcyc_t run_cur [NDUT];
   int    run_len [NDUT];

   always #5 clk = ~clk;

   function automatic int wc_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
   endfunction

   function automatic logic [3:0] bank_of(input int p);
      return (p == 0) ? 4'h0 : 4'h1;
   endfunction

   function automatic logic [6:0] midx(input logic [20:0] a);
      return {a[17], a[5:0]};
   endfunction

   function automatic logic [7:0] init_byte(input logic [6:0] i);
      if (i == 7'd70) return 8'h34;
      if (i == 7'd71) return 8'h12;
      return 8'(i) * 8'd7 + 8'd3;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .p0_req     (p0_req[g]),
         .p1_req     (p1_req[g]),
         .p0_we      (p0_we[g]),
         .p1_we      (p1_we[g]),
         .p0_addr    (p0_addr[g]),
         .p1_addr    (p1_addr[g]),
         .p0_wdata   (p0_wdata[g]),
         .p1_wdata   (p1_wdata[g]),
         .p0_rdata   (p0_rdata[g]),
         .p1_rdata   (p1_rdata[g]),
         .p0_ack     (p0_ack[g]),
         .p1_ack     (p1_ack[g]),
         .sram_addr  (sram_addr[g]),
         .sram_dout  (sram_dout[g]),
         .sram_drive (sram_drive[g]),
         .sram_din   (sram_din[g]),
         .sram_ce    (sram_ce[g]),
         .sram_oe    (sram_oe[g]),
         .sram_we    (sram_we[g])
      );
      assign sram_din[g] = (sram_oe[g] == 1'b0) ? sram_mem[g][midx(sram_addr[g])] : 8'h00;
   end

   // SRAM byte storage: written while we is low
   always @(posedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (mem_init) begin
            for (int i = 0; i < 128; i++) sram_mem[d][i] <= init_byte(7'(i));
         end else if (sram_we[d] == 1'b0) begin
            sram_mem[d][midx(sram_addr[d])] <= sram_dout[d];
         end
      end
   end

   // Pin monitor: strobe exclusion, drive-before-we, single ack, strobe log
   always @(negedge clk) begin
      logic excl, drv_ok, one_ack;
      for (int d = 0; d < NDUT; d++) begin
         excl    = !(sram_oe[d] == 1'b0 && sram_we[d] == 1'b0);
         drv_ok  = !(sram_we[d] == 1'b0 && sram_drive[d] == 1'b0);
         one_ack = !(p0_ack[d] == 1'b1 && p1_ack[d] == 1'b1);
         tests += 3;
         assert (excl === 1'b1) else begin
            fails++; $error("FAIL oe_we_excl dut%0d: observed %b expected 1", d, excl);
         end
         assert (drv_ok === 1'b1) else begin
            fails++; $error("FAIL we_needs_drive dut%0d: observed %b expected 1", d, drv_ok);
         end
         assert (one_ack === 1'b1) else begin
            fails++; $error("FAIL single_ack dut%0d: observed %b expected 1", d, one_ack);
         end
         if (sram_oe[d] == 1'b0 || sram_we[d] == 1'b0) begin
            if (run_len[d] == 0) begin
               run_cur[d].d    = d;
               run_cur[d].addr = sram_addr[d];
               run_cur[d].dout = sram_dout[d];
               run_cur[d].wr   = (sram_we[d] == 1'b0);
            end
            run_len[d]++;
         end else if (run_len[d] != 0) begin
            run_cur[d].width = run_len[d];
            blog.push_back(run_cur[d]);
            run_len[d] = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int d, input int p, input logic r, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd);
      if (p == 0) begin
         p0_req[d] = r; p0_we[d] = wr; p0_addr[d] = a; p0_wdata[d] = wd;
      end else begin
         p1_req[d] = r; p1_we[d] = wr; p1_addr[d] = a; p1_wdata[d] = wd;
      end
   endtask

   task automatic reset_model();
      for (int d = 0; d < NDUT; d++) begin
         last_rd[d][0]  = 16'h0;
         last_rd[d][1]  = 16'h0;
         last_served[d] = -1;
      end
   endtask

   // One word transfer on a single port; checks latency, pin bytes, rdata
   task automatic xfer(input int d, input int p, input logic wr, input logic [4:0] a5,
                       input logic [15:0] wd);
      int          w, n;
      logic        got;
      logic [15:0] a, e;
      w = wc_of(d);
      a = {11'd0, a5};
      @(negedge clk);
      blog.delete();
      set_req(d, p, 1'b1, wr, a, wd);
      n   = 0;
      got = 1'b0;
      while (!got && n < 2 * w + 20) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? p0_ack[d] : p1_ack[d];
      end
      set_req(d, p, 1'b0, 1'b0, 16'h0, 16'h0);
      check("ack_cycle", n, 2 * w + 5);
      check("ce_high_at_ack", sram_ce[d], 1'b1);
      check("byte_count", blog.size(), 2);
      for (int b = 0; b < 2 && b < blog.size(); b++) begin
         check("byte_addr", blog[b].addr, {bank_of(p), a, 1'(b)});
         check("byte_dir", blog[b].wr, wr);
         check("strobe_width", blog[b].width, w);
         if (wr) check("byte_data", blog[b].dout, (b == 0) ? wd[7:0] : wd[15:8]);
      end
      if (wr) begin
         ref_mem[d][p][a5] = wd;
      end else begin
         e = ref_mem[d][p][a5];
         last_rd[d][p] = e;
      end
      last_served[d] = p;
      check("rdata_p0", p0_rdata[d], last_rd[d][0]);
      check("rdata_p1", p1_rdata[d], last_rd[d][1]);
   endtask

   // Both ports read continuously for three words
   task automatic arb_test(input int d);
      int          w, n, acks, got, exp_p;
      logic [4:0]  a0, a1;
      logic [15:0] e;
      w  = wc_of(d);
      a0 = 5'($urandom_range(0, 31));
      a1 = 5'($urandom_range(0, 31));
      @(negedge clk);
      set_req(d, 0, 1'b1, 1'b0, {11'd0, a0}, 16'h0);
      set_req(d, 1, 1'b1, 1'b0, {11'd0, a1}, 16'h0);
      n    = 0;
      acks = 0;
      while (acks < 3 && n < 4 * (2 * w + 6)) begin
         @(negedge clk);
         n++;
         if (p0_ack[d] == 1'b1 || p1_ack[d] == 1'b1) begin
            got = (p1_ack[d] == 1'b1) ? 1 : 0;
`ifdef SRAM_ARB_RR_EN
            exp_p = (last_served[d] == 0) ? 1 : 0;
`else
            exp_p = 0;
`endif
            check("arb_winner", got, exp_p);
            check("arb_cycle", n, (acks + 1) * (2 * w + 6) - 1);
            e = ref_mem[d][got][(got == 1) ? a1 : a0];
            last_rd[d][got] = e;
            check("arb_rdata", (got == 1) ? p1_rdata[d] : p0_rdata[d], e);
            last_served[d] = got;
            acks++;
            if (acks == 3) begin
               set_req(d, 0, 1'b0, 1'b0, 16'h0, 16'h0);
               set_req(d, 1, 1'b0, 1'b0, 16'h0, 16'h0);
            end
         end
      end
      set_req(d, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_req(d, 1, 1'b0, 1'b0, 16'h0, 16'h0);
      check("arb_acks", acks, 3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      mem_init = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         run_len[d] = 0;
         set_req(d, 0, 1'b0, 1'b0, 16'h0, 16'h0);
         set_req(d, 1, 1'b0, 1'b0, 16'h0, 16'h0);
         for (int p = 0; p < 2; p++)
            for (int a = 0; a < 32; a++)
               ref_mem[d][p][a] = {init_byte({1'(p), 5'(a), 1'b1}), init_byte({1'(p), 5'(a), 1'b0})};
      end
      reset_model();
      repeat (3) @(negedge clk);

      for (int d = 0; d < NDUT; d++) begin
         check("rst_ce", sram_ce[d], 1'b1);
         check("rst_oe", sram_oe[d], 1'b1);
         check("rst_we", sram_we[d], 1'b1);
         check("rst_drive", sram_drive[d], 1'b0);
         check("rst_addr", sram_addr[d], 21'h0);
         check("rst_dout", sram_dout[d], 8'h0);
         check("rst_ack0", p0_ack[d], 1'b0);
         check("rst_ack1", p1_ack[d], 1'b0);
         check("rst_rdata0", p0_rdata[d], 16'h0);
         check("rst_rdata1", p1_rdata[d], 16'h0);
      end
      mem_init = 1'b0;
      rst      = 1'b1;

      // Directed: BEEF write on port 0, 1234 read on port 1
      xfer(0, 0, 1'b1, 5'h10, 16'hBEEF);
      xfer(0, 1, 1'b0, 5'h03, 16'h0000);
      check("directed_read", p1_rdata[0], 16'h1234);

      for (int d = 0; d < NDUT; d++) arb_test(d);

      // Reset during the high-byte write strobe
      @(negedge clk);
      set_req(0, 0, 1'b1, 1'b1, 16'h0007, 16'hA55A);
      repeat (wc_of(0) + 4) @(negedge clk);
      check("rst_pre_we", sram_we[0], 1'b0);
      check("rst_pre_bsel", sram_addr[0][0], 1'b1);
      rst = 1'b0;
      #1;
      check("arst_ce", sram_ce[0], 1'b1);
      check("arst_oe", sram_oe[0], 1'b1);
      check("arst_we", sram_we[0], 1'b1);
      check("arst_drive", sram_drive[0], 1'b0);
      check("arst_addr", sram_addr[0], 21'h0);
      set_req(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      reset_model();
      repeat (3) begin
         @(negedge clk);
         check("arst_no_ack", p0_ack[0], 1'b0);
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("arst_no_ack_after", p0_ack[0], 1'b0);
      end
      check("arst_rdata", p1_rdata[0], 16'h0);
      xfer(0, 0, 1'b1, 5'h07, 16'h5AA5);
      xfer(0, 0, 1'b0, 5'h07, 16'h0000);

      // Randomized single-port traffic on every instance
      for (int d = 0; d < NDUT; d++) begin
         for (int k = 0; k < ((d == 2) ? 6 : 14); k++) begin
            xfer(d, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 16'($urandom));
         end
         arb_test(d);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
